// File: rtl/load_arbiter_if.sv
// -----------------------------------------------------------------------------
// load_arbiter_if
// Bundles the request, RAM-read and local-memory-write signals of the burst
// load arbiter.
//
//   req      NREQ      per-core burst-load request (level)
//   pivot    NREQ*AW   per-core RAM base address, slice i belongs to core i
//   len      NREQ*LW   per-core word count, slice i belongs to core i
//   gnt      NREQ      one-hot grant, held for the whole burst
//   ramRd    1         RAM read strobe, one cycle per word
//   ramAddr  AW        RAM read address
//   ramData  DW        RAM read data
//   ramValid 1         RAM read data valid (>= 1 cycle after ramRd)
//   wrEn     1         local-memory write strobe
//   wrAddr   LW        local-memory offset
//   wrData   DW        local-memory write word
//   done     NREQ      one-cycle completion pulse
//   busy     1         arbiter not idle
//
// Modports: master = the arbiter, slave = cores plus RAM.
// -----------------------------------------------------------------------------
interface load_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 16,
    parameter int DW   = 8,
    parameter int LW   = 7
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] pivot;
    logic [NREQ*LW-1:0] len;
    logic [NREQ-1:0]    gnt;
    logic               ramRd;
    logic [AW-1:0]      ramAddr;
    logic [DW-1:0]      ramData;
    logic               ramValid;
    logic               wrEn;
    logic [LW-1:0]      wrAddr;
    logic [DW-1:0]      wrData;
    logic [NREQ-1:0]    done;
    logic               busy;

    modport master (
        input  req, pivot, len, ramData, ramValid,
        output gnt, ramRd, ramAddr, wrEn, wrAddr, wrData, done, busy
    );

    modport slave (
        output req, pivot, len, ramData, ramValid,
        input  gnt, ramRd, ramAddr, wrEn, wrAddr, wrData, done, busy
    );
endinterface

// File: rtl/load_arbiter.sv
// -----------------------------------------------------------------------------
// load_arbiter
// Grants one of NREQ cores a burst load: reads len words from RAM starting at
// the core's pivot address (wrapping modulo 2^AW), one read outstanding at a
// time, and forwards each returned word to the core's local memory at offsets
// 0..len-1.
//
// Ports:
//   fastClk  in   sole clock, all logic on posedge
//   rst      in   synchronous reset, active-high
//   bus      load_arbiter_if.master (req/pivot/len in, gnt/ramRd/ramAddr out,
//            ramData/ramValid in, wrEn/wrAddr/wrData/done/busy out)
//
// Configuration:
//   LARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                       undefined -> round-robin from ptr (default)
// -----------------------------------------------------------------------------
module load_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 16,
    parameter int DW   = 8,
    parameter int LW   = 7
) (
    input  logic           fastClk,
    input  logic           rst,
    load_arbiter_if.master bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

    state_t          state;
    logic [NREQ-1:0] gntQ;
    logic [NREQ-1:0] doneQ;
    logic            ramRdQ;
    logic [AW-1:0]   ramAddrQ;
    logic [AW-1:0]   pivotQ;
    logic [LW-1:0]   lenQ;
    logic [LW-1:0]   cnt;

    logic            anyReq;
    logic [PW-1:0]   winner;
    logic [AW-1:0]   winPivot;
    logic [LW-1:0]   winLen;
    logic [LW-1:0]   cntNext;
    logic            wrFire;

    logic [AW-1:0]   pivotArr [NREQ];
    logic [LW-1:0]   lenArr   [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign pivotArr[g] = bus.pivot[g*AW +: AW];
        assign lenArr[g]   = bus.len[g*LW +: LW];
    end

`ifndef LARB_FIXED_PRIO_EN
    logic [PW-1:0] ptr;
    logic [PW-1:0] winQ;
    logic [PW-1:0] rrSel;
    int            rrIdx;
`endif

    // Winner selection. Iterating from the lowest priority to the highest lets
    // the last hit win without a break.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        anyReq = 1'b0;
        winner = '0;
`ifdef LARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[PW'(i)]) begin
                anyReq = 1'b1;
                winner = PW'(i);
            end
        end
`else
        rrIdx = 0;
        rrSel = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            rrIdx = int'(ptr) + i;
            if (rrIdx >= NREQ) rrIdx = rrIdx - NREQ;
            rrSel = PW'(rrIdx);
            if (bus.req[rrSel]) begin
                anyReq = 1'b1;
                winner = rrSel;
            end
        end
`endif
    end

    assign winPivot = pivotArr[winner];
    assign winLen   = lenArr[winner];
    assign cntNext  = cnt + LW'(1);

    // Only a response arriving while a read is outstanding is accepted; stale
    // or spurious ramValid in any other state is dropped.
    assign wrFire = (state == WAIT) && bus.ramValid;

    always_ff @(posedge fastClk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            // NOTE: the latched burst descriptor is reset along with the
            // control state so nothing from an aborted burst survives reset.
            state    <= IDLE;
            gntQ     <= '0;
            doneQ    <= '0;
            ramRdQ   <= 1'b0;
            ramAddrQ <= '0;
            pivotQ   <= '0;
            lenQ     <= '0;
            cnt      <= '0;
`ifndef LARB_FIXED_PRIO_EN
            ptr      <= '0;
            winQ     <= '0;
`endif
        end else begin
            // Strobes are single-cycle unless a transition re-arms them.
            ramRdQ <= 1'b0;
            doneQ  <= '0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        pivotQ <= winPivot;
                        lenQ   <= winLen;
                        cnt    <= '0;
                        gntQ   <= NREQ'(1) << winner;
`ifndef LARB_FIXED_PRIO_EN
                        winQ   <= winner;
`endif
                        if (winLen == '0) begin
                            state <= DONE;
                            doneQ <= NREQ'(1) << winner;
                        end else begin
                            state    <= RUN;
                            ramRdQ   <= 1'b1;
                            ramAddrQ <= winPivot;
                        end
                    end
                end
                RUN: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.ramValid) begin
                        cnt <= cntNext;
                        if (cntNext == lenQ) begin
                            state <= DONE;
                            doneQ <= gntQ;
                        end else begin
                            state    <= RUN;
                            ramRdQ   <= 1'b1;
                            ramAddrQ <= pivotQ + AW'(cntNext);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gntQ  <= '0;
`ifndef LARB_FIXED_PRIO_EN
                    ptr   <= (winQ == PW'(NREQ - 1)) ? '0 : winQ + PW'(1);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gntQ;
    assign bus.done    = doneQ;
    assign bus.ramRd   = ramRdQ;
    assign bus.ramAddr = ramAddrQ;
    assign bus.wrEn    = wrFire;
    assign bus.wrAddr  = wrFire ? cnt : '0;
    assign bus.wrData  = wrFire ? bus.ramData : '0;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_load_arbiter.sv
// -----------------------------------------------------------------------------
// tb_load_arbiter
// Self-checking bench for load_arbiter: a directed burst table, hand-written
// multi-cycle sequences (grant order, reset mid-burst, request dropped during
// a slow burst) and randomized multi-burst runs compared against a
// transaction-level model of the arbitration rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_load_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int LW   = 7;

    logic fastClk = 1'b0;
    logic rst;

    load_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) bus ();

    load_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) dut (
        .fastClk (fastClk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 fastClk = ~fastClk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ramWord(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // ---------------- RAM responder ----------------
    typedef struct { logic [AW-1:0] addr; int due; } pend_t;
    pend_t pend[$];
    int    cyc      = 0;
    int    lat      = 1;
    bit    spurious = 1'b0;

    initial begin
        pend_t dummy;
        bus.ramValid = 1'b0;
        bus.ramData  = '0;
        forever begin
            @(posedge fastClk);
            cyc++;
            #1;
            bus.ramValid = 1'b0;
            bus.ramData  = DW'($urandom);
            if (pend.size() > 0) begin
                if (pend[0].due <= cyc) begin
                    bus.ramValid = 1'b1;
                    bus.ramData  = ramWord(pend[0].addr);
                    dummy = pend.pop_front();
                end
            end else if (spurious && $urandom_range(0, 3) == 0) begin
                bus.ramValid = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    typedef struct { logic [LW-1:0] addr; logic [DW-1:0] data; } wr_t;
    logic [AW-1:0] rdLog[$];
    wr_t           wrLog[$];
    int            doneLog[$];
    int            gntCycles[NREQ];
    int            outstanding = 0;

    initial begin
        forever begin
            @(negedge fastClk);
            if (rst) begin
                outstanding = 0;
            end else begin
                if (bus.gnt != '0) begin
                    check("gnt one-hot", 32'($onehot(bus.gnt)), 32'd1);
                    for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) gntCycles[i]++;
                end
                if (bus.ramRd) begin
                    check("single outstanding read", outstanding, 0);
                    outstanding++;
                    rdLog.push_back(bus.ramAddr);
                    pend.push_back('{bus.ramAddr, cyc + lat});
                end
                if (bus.wrEn) begin
                    outstanding--;
                    wrLog.push_back('{bus.wrAddr, bus.wrData});
                end
                if (bus.done != '0) begin
                    check("done matches gnt", 32'(bus.done), 32'(bus.gnt));
                    for (int i = 0; i < NREQ; i++) if (bus.done[i]) doneLog.push_back(i);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [AW-1:0]   pivGold[NREQ];
    int              lenGold[NREQ];
    logic [NREQ-1:0] reqGold;

    task automatic applyGold();
        for (int i = 0; i < NREQ; i++) begin
            bus.pivot[i*AW +: AW] = pivGold[i];
            bus.len[i*LW +: LW]   = LW'(lenGold[i]);
        end
        bus.req = reqGold;
    endtask

    task automatic scramble();
        for (int i = 0; i < NREQ; i++) begin
            bus.pivot[i*AW +: AW] = AW'($urandom);
            bus.len[i*LW +: LW]   = LW'($urandom);
        end
        bus.req = NREQ'($urandom);
    endtask

    task automatic clearLogs();
        rdLog.delete();
        wrLog.delete();
        doneLog.delete();
        for (int i = 0; i < NREQ; i++) gntCycles[i] = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge fastClk);
            #1;
        end
    endtask

    task automatic doReset();
        @(negedge fastClk);
        #1;
        rst     = 1'b1;
        reqGold = '0;
        applyGold();
        @(posedge fastClk);
        @(posedge fastClk);
        @(negedge fastClk);
        #1;
        rst = 1'b0;
    endtask

    // Runs until n done pulses were seen, then drops all requests during the
    // final DONE cycle so no further burst starts.
    task automatic runUntilDones(input int n, input int budget, input bit mess);
        int c;
        c = 0;
        while (doneLog.size() < n && c < budget) begin
            @(negedge fastClk);
            #1;
            c++;
            if (mess) begin
                if (bus.done != '0) applyGold();
                else if (bus.busy && $urandom_range(0, 2) == 0) scramble();
            end
        end
        reqGold = '0;
        applyGold();
        check("bursts finish within budget", 32'(doneLog.size() >= n), 32'd1);
    endtask

    function automatic int seqErrors(input logic [AW-1:0] piv, input int n);
        int bad;
        logic [AW-1:0] a;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            a = AW'(32'(piv) + k);
            if (k >= rdLog.size()) bad++;
            else if (rdLog[k] !== a) bad++;
            if (k >= wrLog.size()) bad++;
            else if (wrLog[k].addr !== LW'(k) || wrLog[k].data !== ramWord(a)) bad++;
        end
        return bad;
    endfunction

    // ---------------- reference model ----------------
    int modelPtr = 0;

    function automatic int pickWinner(input logic [NREQ-1:0] r, input int p);
`ifdef LARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (r[i]) return i + 0 * p;
`else
        for (int i = 0; i < NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
`endif
        return -1;
    endfunction

    task automatic randomTrial(input int t);
        int            expOrder[$];
        logic [AW-1:0] expRd[$];
        wr_t           expWr[$];
        int            n, w, badO, badR, badW;
        logic [AW-1:0] a;
        n   = 4;
        lat = $urandom_range(1, 3);
        do reqGold = NREQ'($urandom); while (reqGold == '0);
        for (int i = 0; i < NREQ; i++) begin
            pivGold[i] = AW'($urandom);
            lenGold[i] = $urandom_range(0, 5);
        end
        for (int b = 0; b < n; b++) begin
            w = pickWinner(reqGold, modelPtr);
            expOrder.push_back(w);
            for (int k = 0; k < lenGold[w]; k++) begin
                a = AW'(32'(pivGold[w]) + k);
                expRd.push_back(a);
                expWr.push_back('{LW'(k), ramWord(a)});
            end
            modelPtr = (w + 1) % NREQ;
        end
        clearLogs();
        applyGold();
        runUntilDones(n, 3000, 1'b1);
        cycles(2);
        badO = (doneLog.size() == n) ? 0 : 1;
        for (int i = 0; i < n && i < doneLog.size(); i++) if (doneLog[i] != expOrder[i]) badO++;
        badR = (rdLog.size() == expRd.size()) ? 0 : 1;
        for (int i = 0; i < expRd.size() && i < rdLog.size(); i++) if (rdLog[i] !== expRd[i]) badR++;
        badW = (wrLog.size() == expWr.size()) ? 0 : 1;
        for (int i = 0; i < expWr.size() && i < wrLog.size(); i++)
            if (wrLog[i].addr !== expWr[i].addr || wrLog[i].data !== expWr[i].data) badW++;
        check($sformatf("rand%0d grant order errors", t), badO, 0);
        check($sformatf("rand%0d read address errors", t), badR, 0);
        check($sformatf("rand%0d write errors", t), badW, 0);
        check($sformatf("rand%0d busy after", t), 32'(bus.busy), 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int            core;
        logic [AW-1:0] pivot;
        int            len;
        int            lat;
        int            expReads;
        logic [AW-1:0] expFirst;
        logic [AW-1:0] expLast;
        int            expGnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int bad, k, c, total;
        int expOrder[5];

        vecs[0] = '{0, 16'h0100,   3, 1,   3, 16'h0100, 16'h0102,   7};
        vecs[1] = '{2, 16'hFFFE,   4, 1,   4, 16'hFFFE, 16'h0001,   9};
        vecs[2] = '{1, 16'h1234,   0, 1,   0, 16'h0000, 16'h0000,   1};
        vecs[3] = '{3, 16'h8000,   2, 2,   2, 16'h8000, 16'h8001,   7};
        vecs[4] = '{0, 16'h0000, 127, 1, 127, 16'h0000, 16'h007E, 255};

        rst     = 1'b1;
        reqGold = '0;
        for (int i = 0; i < NREQ; i++) begin
            pivGold[i] = '0;
            lenGold[i] = 0;
        end
        applyGold();
        repeat (3) @(posedge fastClk);
        @(negedge fastClk);
        #1;
        rst = 1'b0;
        cycles(1);

        check("reset gnt", 32'(bus.gnt), 0);
        check("reset ramRd", 32'(bus.ramRd), 0);
        check("reset ramAddr", 32'(bus.ramAddr), 0);
        check("reset wrEn", 32'(bus.wrEn), 0);
        check("reset wrAddr", 32'(bus.wrAddr), 0);
        check("reset wrData", 32'(bus.wrData), 0);
        check("reset done", 32'(bus.done), 0);
        check("reset busy", 32'(bus.busy), 0);

        // Single bursts from the table.
        for (int v = 0; v < 5; v++) begin
            clearLogs();
            lat     = vecs[v].lat;
            reqGold = NREQ'(1) << vecs[v].core;
            pivGold[vecs[v].core] = vecs[v].pivot;
            lenGold[vecs[v].core] = vecs[v].len;
            applyGold();
            runUntilDones(1, 2000, 1'b0);
            cycles(2);
            check($sformatf("v%0d reads", v), rdLog.size(), vecs[v].expReads);
            check($sformatf("v%0d writes", v), wrLog.size(), vecs[v].expReads);
            if (vecs[v].expReads > 0 && rdLog.size() > 0) begin
                check($sformatf("v%0d first addr", v), 32'(rdLog[0]), 32'(vecs[v].expFirst));
                check($sformatf("v%0d last addr", v), 32'(rdLog[rdLog.size()-1]), 32'(vecs[v].expLast));
            end
            check($sformatf("v%0d sequence errors", v), seqErrors(vecs[v].pivot, vecs[v].len), 0);
            check($sformatf("v%0d done pulses", v), doneLog.size(), 1);
            check($sformatf("v%0d done core", v), (doneLog.size() > 0) ? doneLog[0] : -1, vecs[v].core);
            check($sformatf("v%0d gnt cycles", v), gntCycles[vecs[v].core], vecs[v].expGnt);
            total = 0;
            for (int i = 0; i < NREQ; i++) total += gntCycles[i];
            check($sformatf("v%0d no other grant", v), total, vecs[v].expGnt);
            check($sformatf("v%0d busy after", v), 32'(bus.busy), 0);
            lenGold[vecs[v].core] = 0;
        end

        // Grant order with every core requesting, one-word bursts.
        doReset();
        clearLogs();
        lat = 1;
        for (int i = 0; i < NREQ; i++) begin
            pivGold[i] = AW'(32'h1000 * (i + 1));
            lenGold[i] = 1;
        end
        reqGold = '1;
        applyGold();
        runUntilDones(5, 500, 1'b0);
        cycles(2);
`ifdef LARB_FIXED_PRIO_EN
        expOrder = '{0, 0, 0, 0, 0};
`else
        expOrder = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 5; i++)
            check($sformatf("grant order %0d", i), (i < doneLog.size()) ? doneLog[i] : -1, expOrder[i]);

        // Reset while waiting on the third word of a five-word burst; the
        // read already issued answers after reset is released.
        clearLogs();
        lat = 3;
        for (int i = 0; i < NREQ; i++) lenGold[i] = 0;
        pivGold[0] = 16'h0200;
        lenGold[0] = 5;
        reqGold    = 4'b0001;
        applyGold();
        c = 0;
        while (rdLog.size() < 3 && c < 200) begin
            cycles(1);
            c++;
        end
        check("third read issued", rdLog.size(), 3);
        cycles(1);
        check("writes before reset", wrLog.size(), 2);
        rst     = 1'b1;
        reqGold = '0;
        applyGold();
        @(posedge fastClk);
        @(negedge fastClk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cycles(1);
            if (bus.gnt != '0 || bus.ramRd || bus.ramAddr != '0 || bus.wrEn ||
                bus.wrAddr != '0 || bus.wrData != '0 || bus.done != '0 || bus.busy) bad++;
        end
        check("outputs idle after mid-burst reset", bad, 0);
        check("late ramValid delivered", pend.size(), 0);
        check("no write from late ramValid", wrLog.size(), 2);

        // Slow RAM, request dropped after the first word.
        clearLogs();
        lat        = 3;
        pivGold[3] = 16'h4000;
        lenGold[3] = 4;
        reqGold    = 4'b1000;
        applyGold();
        c = 0;
        while (wrLog.size() < 1 && c < 200) begin
            cycles(1);
            c++;
        end
        check("first slow write seen", wrLog.size(), 1);
        reqGold = '0;
        applyGold();
        runUntilDones(1, 500, 1'b0);
        cycles(3);
        check("slow burst writes", wrLog.size(), 4);
        check("slow burst reads", rdLog.size(), 4);
        check("slow burst sequence errors", seqErrors(16'h4000, 4), 0);
        check("slow burst done core", (doneLog.size() == 1) ? doneLog[0] : -1, 3);
        check("slow burst gnt cycles", gntCycles[3], 17);
        check("slow burst busy after", 32'(bus.busy), 0);

        // Randomized multi-burst runs against the model.
        doReset();
        modelPtr = 0;
        spurious = 1'b1;
        for (int t = 0; t < 12; t++) randomTrial(t);
        spurious = 1'b0;

        k = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors + k);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/load_arbiter.md
LOAD_ARBITER -- requirements
Module: load_arbiter

Interface
REQ-001 The block SHALL have parameters NREQ, default 4, number of requesting cores.
REQ-002 The block SHALL have parameters AW, default 16, RAM address width.
REQ-003 The block SHALL have parameters DW, default 8, data word width.
REQ-004 The block SHALL have parameters LW, default 7, local-memory offset and length width.
REQ-005 The block SHALL have ports: fastClk  in  1  sole clock, all logic on posedge.
REQ-006 The block SHALL have ports: rst  in  1  synchronous reset, active-high.
REQ-007 The block SHALL have ports: req  in  NREQ  per-core burst-load request, level.
REQ-008 The block SHALL have ports: pivot  in  NREQ*AW  per-core RAM base address, slice i = core i.
REQ-009 The block SHALL have ports: len  in  NREQ*LW  per-core word count.
REQ-010 The block SHALL have ports: gnt  out  NREQ  one-hot grant, held for the whole burst.
REQ-011 The block SHALL have ports: ramRd  out  1  RAM read strobe, one cycle per word.
REQ-012 The block SHALL have ports: ramAddr  out  AW  RAM read address.
REQ-013 The block SHALL have ports: ramData  in  DW  RAM read data; ramValid  in  1  data valid, latency >= 1 cycle after ramRd.
REQ-014 The block SHALL have ports: wrEn  out  1  core local-memory write strobe; wrAddr  out  LW  local offset; wrData  out  DW  word.
REQ-015 The block SHALL have ports: done  out  NREQ  one-cycle completion pulse; busy  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, WAIT, DONE.
REQ-017 In IDLE with any req bit high, the FSM SHALL select a winner w, latch pivot[w] and len[w], clear cnt, and in the next cycle assert gnt[w] and enter RUN (or DONE if latched len = 0).
REQ-018 Arbitration SHALL be round-robin: search from ptr upward modulo NREQ; ptr <= (w+1) mod NREQ on leaving DONE.
REQ-019 In RUN the block SHALL assert ramRd for exactly one cycle with ramAddr = (pivot + cnt) mod 2^AW, then enter WAIT; at most one read SHALL be outstanding.
REQ-020 In WAIT, on ramValid, the block SHALL drive wrEn=1, wrData=ramData, wrAddr=cnt in that same cycle, increment cnt, and enter DONE if cnt+1 = len, else enter RUN.
REQ-021 ramValid outside WAIT SHALL be ignored.
REQ-022 In DONE the block SHALL pulse done[w] for one cycle, drop gnt to 0 on the following cycle, and return to IDLE.
REQ-023 In DONE, req[w] SHALL be masked for that cycle; a requester still high afterwards is re-arbitrated as a new burst.
REQ-024 Changes to req, pivot or len during a burst SHALL be ignored; the burst completes with its latched values.
REQ-025 len = 2^LW-1 SHALL produce that many writes; wrAddr SHALL never exceed len-1.
REQ-026 ramRd, wrEn and done SHALL be 0 in every state not listed as driving them.

Reset
REQ-027 On rst high at a posedge, including mid-burst, the block SHALL force state=IDLE, ptr=0, cnt=0, and gnt, ramRd, ramAddr, wrEn, wrAddr, wrData, done, busy to 0.
REQ-028 A ramValid for a read issued before reset SHALL be ignored.

Configuration
REQ-029 With LARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority, lowest index wins, and ptr SHALL be absent.
REQ-030 Without LARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-018.

Verification
REQ-031 The bench SHALL cover: req[0]=1, pivot0=0x0100, len0=3, RAM latency 1 -> ramAddr 0x0100,0x0101,0x0102; wrAddr 0,1,2; one done[0] pulse; gnt[0] high throughout.
REQ-032 The bench SHALL cover: req=4'b1111 held, all len=1 -> grant order 0,1,2,3,0 (round-robin); with LARB_FIXED_PRIO_EN, repeated order 0,0,... while req[0] is held.
REQ-033 The bench SHALL cover: pivot2=0xFFFE, len2=4 -> ramAddr 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-034 The bench SHALL cover: len1=0 -> gnt[1] held one cycle, done[1] pulse, no ramRd and no wrEn.
REQ-035 The bench SHALL cover: rst asserted while in WAIT with len=5 after 2 writes, then late ramValid -> all outputs 0, no wrEn, busy=0.
REQ-036 The bench SHALL cover: RAM latency 3 with req[3] dropped mid-burst, len3=4 -> 4 writes complete, one ramRd per word, never 2 outstanding.
